// File: rtl/calc_pkg.sv
// Shared opcode encoding and flag bit positions for the accumulator calculator.
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_OR   = 4'h2,
        OP_AND  = 4'h3,
        OP_XOR  = 4'h4,
        OP_LSL  = 4'h5,
        OP_LSR  = 4'h6,
        OP_ASR  = 4'h7,
        OP_NEG  = 4'h8,
        OP_INV  = 4'h9,
        OP_REV  = 4'hA,
        OP_UNDO = 4'hB,
        OP_LOAD = 4'hC,
        OP_LT   = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } opcode_e;

    localparam int FLG_CARRY = 2;
    localparam int FLG_NEG   = 1;
    localparam int FLG_ZERO  = 0;

endpackage

// File: rtl/calc_hist_stack.sv
// Circular LIFO of prior accumulator values; a push when full overwrites the oldest entry.
module calc_hist_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_idx;

    // Most recent entry sits one slot behind the write pointer, wrapping at DEPTH.
    always_comb begin
        top_idx = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
        dout    = mem[top_idx];
    end

    // Write pointer and valid count; the count saturates so old entries are silently lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (count != CW'(DEPTH))
                count <= count + CW'(1);
        end else if (pop && count != '0) begin
            wr_ptr <= top_idx;
            count  <= count - CW'(1);
        end
    end

    // Entry storage; contents beyond count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/calc_accum_core.sv
// Accumulator ALU with edge-detected strobe, undo history, status flags and done/error pulses.
module calc_accum_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       op_strobe,
    input  logic [3:0]                 op,
    input  logic [WIDTH-1:0]           operand,
    output logic [WIDTH-1:0]           acc_out,
    output logic [2:0]                 flags,
    output logic                       done,
    output logic                       undo_err,
    output logic [$clog2(DEPTH+1)-1:0] hist_count
);

    logic             strobe_q;
    logic             fire;
    opcode_e          opc;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             writes;
    logic             is_cmp;
    logic             is_undo;
    logic             cond;
    logic             hist_empty;
    logic [WIDTH-1:0] hist_top;
    logic             push;
    logic             pop;

    assign fire       = ena & op_strobe & ~strobe_q;
    assign hist_empty = (hist_count == '0);
    assign push       = fire & writes;
    assign pop        = fire & is_undo & ~hist_empty;

    calc_hist_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_hist (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (acc_out),
        .dout (hist_top),
        .count(hist_count)
    );

    // ALU next value, carry and op class for the current opcode.
    always_comb begin
        opc     = opcode_e'(op);
        wide    = '0;
        res     = acc_out;
        carry   = 1'b0;
        writes  = 1'b0;
        is_cmp  = 1'b0;
        is_undo = 1'b0;
        cond    = 1'b0;
        case (opc)
            OP_ADD: begin
                wide   = {1'b0, acc_out} + {1'b0, operand};
                res    = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
                writes = 1'b1;
            end
            OP_SUB: begin
                wide   = {1'b0, acc_out} - {1'b0, operand};
                res    = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
                writes = 1'b1;
            end
            OP_OR:  begin res = acc_out | operand; writes = 1'b1; end
            OP_AND: begin res = acc_out & operand; writes = 1'b1; end
            OP_XOR: begin res = acc_out ^ operand; writes = 1'b1; end
            OP_LSL: begin
                res    = {acc_out[WIDTH-2:0], 1'b0};
                carry  = acc_out[WIDTH-1];
                writes = 1'b1;
            end
            OP_LSR: begin
                res    = {1'b0, acc_out[WIDTH-1:1]};
                carry  = acc_out[0];
                writes = 1'b1;
            end
            OP_ASR: begin
                res    = {acc_out[WIDTH-1], acc_out[WIDTH-1:1]};
                carry  = acc_out[0];
                writes = 1'b1;
            end
            OP_NEG: begin res = '0 - acc_out; writes = 1'b1; end
            OP_INV: begin res = ~acc_out; writes = 1'b1; end
            OP_REV: begin
                for (int unsigned i = 0; i < WIDTH; i++)
                    res[i] = acc_out[WIDTH-1-i];
                writes = 1'b1;
            end
            OP_UNDO: is_undo = 1'b1;
            OP_LOAD: begin res = operand; writes = 1'b1; end
            OP_LT: begin is_cmp = 1'b1; cond = $signed(acc_out) <  $signed(operand); end
            OP_GT: begin is_cmp = 1'b1; cond = $signed(acc_out) >  $signed(operand); end
            OP_EQ: begin is_cmp = 1'b1; cond = (acc_out == operand); end
            default: ;
        endcase
    end

    // Strobe edge tracking, accumulator/flag commit and one-cycle result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b1;
            acc_out  <= '0;
            flags    <= '0;
            done     <= 1'b0;
            undo_err <= 1'b0;
        end else begin
            strobe_q <= op_strobe;
            done     <= fire;
            undo_err <= fire & is_undo & hist_empty;
            if (fire) begin
                if (writes) begin
                    acc_out          <= res;
                    flags[FLG_CARRY] <= carry;
                    flags[FLG_NEG]   <= res[WIDTH-1];
                    flags[FLG_ZERO]  <= (res == '0);
                end else if (is_cmp) begin
                    flags <= {2'b00, cond};
                end else if (is_undo && !hist_empty) begin
                    acc_out          <= hist_top;
                    flags[FLG_CARRY] <= 1'b0;
                    flags[FLG_NEG]   <= hist_top[WIDTH-1];
                    flags[FLG_ZERO]  <= (hist_top == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_accum_core.sv
// Directed, table-driven check of calc_accum_core at WIDTH=8, DEPTH=4.
module tb_calc_accum_core;
    import calc_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             op_strobe;
    logic [3:0]       op;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc_out;
    logic [2:0]       flags;
    logic             done;
    logic             undo_err;
    logic [CW-1:0]    hist_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst_before;
        logic [3:0] op;
        logic [7:0] operand;
        logic [7:0] acc;
        logic [2:0] flg;
        logic [2:0] hist;
        logic       err;
    } vec_t;

    vec_t vq[$];

    calc_accum_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .op_strobe (op_strobe),
        .op        (op),
        .operand   (operand),
        .acc_out   (acc_out),
        .flags     (flags),
        .done      (done),
        .undo_err  (undo_err),
        .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] o, input logic [7:0] b,
                       input logic [7:0] a, input logic [2:0] f, input logic [2:0] h,
                       input logic e);
        vec_t v;
        v.rst_before = r; v.op = o; v.operand = b; v.acc = a;
        v.flg = f; v.hist = h; v.err = e;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        op_strobe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("reset acc", acc_out, 0);
        check("reset flags", flags, 0);
        check("reset hist", hist_count, 0);
        check("reset done", done, 0);
        check("reset err", undo_err, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        if (v.rst_before) do_reset();
        @(negedge clk);
        op = v.op;
        operand = v.operand;
        op_strobe = 1'b1;
        @(negedge clk);
        check($sformatf("v%0d done", idx), done, 1);
        check($sformatf("v%0d acc", idx), acc_out, v.acc);
        check($sformatf("v%0d flags", idx), flags, v.flg);
        check($sformatf("v%0d hist", idx), hist_count, v.hist);
        check($sformatf("v%0d err", idx), undo_err, v.err);
        op_strobe = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d done_low", idx), done, 0);
        check($sformatf("v%0d err_low", idx), undo_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst = 1'b1; ena = 1'b1; op_strobe = 1'b0; op = '0; operand = '0;

        // ADD wrap and flags
        add(1, OP_ADD, 8'hFF, 8'hFF, 3'b010, 3'd1, 0);
        add(0, OP_ADD, 8'h01, 8'h00, 3'b101, 3'd2, 0);
        // undo basics and empty-undo error
        add(1, OP_LOAD, 8'h10, 8'h10, 3'b000, 3'd1, 0);
        add(0, OP_ADD,  8'h05, 8'h15, 3'b000, 3'd2, 0);
        add(0, OP_SUB,  8'h03, 8'h12, 3'b000, 3'd3, 0);
        add(0, OP_UNDO, 8'h00, 8'h15, 3'b000, 3'd2, 0);
        add(0, OP_UNDO, 8'h00, 8'h10, 3'b000, 3'd1, 0);
        add(0, OP_UNDO, 8'h00, 8'h00, 3'b001, 3'd0, 0);
        add(0, OP_UNDO, 8'h00, 8'h00, 3'b001, 3'd0, 1);
        // overwrite-oldest on full history
        add(1, OP_LOAD, 8'h01, 8'h01, 3'b000, 3'd1, 0);
        add(0, OP_LOAD, 8'h02, 8'h02, 3'b000, 3'd2, 0);
        add(0, OP_LOAD, 8'h03, 8'h03, 3'b000, 3'd3, 0);
        add(0, OP_LOAD, 8'h04, 8'h04, 3'b000, 3'd4, 0);
        add(0, OP_LOAD, 8'h05, 8'h05, 3'b000, 3'd4, 0);
        add(0, OP_LOAD, 8'h06, 8'h06, 3'b000, 3'd4, 0);
        add(0, OP_UNDO, 8'h00, 8'h05, 3'b000, 3'd3, 0);
        add(0, OP_UNDO, 8'h00, 8'h04, 3'b000, 3'd2, 0);
        add(0, OP_UNDO, 8'h00, 8'h03, 3'b000, 3'd1, 0);
        add(0, OP_UNDO, 8'h00, 8'h02, 3'b000, 3'd0, 0);
        add(0, OP_UNDO, 8'h00, 8'h02, 3'b000, 3'd0, 1);
        // signed compares leave acc and history alone
        add(1, OP_LT, 8'h7F, 8'h00, 3'b001, 3'd0, 0);
        add(0, OP_GT, 8'hFF, 8'h00, 3'b001, 3'd0, 0);
        add(0, OP_LT, 8'hFF, 8'h00, 3'b000, 3'd0, 0);
        add(0, OP_EQ, 8'h00, 8'h00, 3'b001, 3'd0, 0);
        // shifts, reverse, negate, invert, logic ops
        add(1, OP_LOAD, 8'h81, 8'h81, 3'b010, 3'd1, 0);
        add(0, OP_LSR,  8'h00, 8'h40, 3'b100, 3'd2, 0);
        add(0, OP_LOAD, 8'h81, 8'h81, 3'b010, 3'd3, 0);
        add(0, OP_ASR,  8'h00, 8'hC0, 3'b110, 3'd4, 0);
        add(0, OP_LOAD, 8'h01, 8'h01, 3'b000, 3'd4, 0);
        add(0, OP_REV,  8'h00, 8'h80, 3'b010, 3'd4, 0);
        add(0, OP_NEG,  8'h00, 8'h80, 3'b010, 3'd4, 0);
        add(0, OP_LOAD, 8'h00, 8'h00, 3'b001, 3'd4, 0);
        add(0, OP_INV,  8'h00, 8'hFF, 3'b010, 3'd4, 0);
        add(0, OP_LOAD, 8'h00, 8'h00, 3'b001, 3'd4, 0);
        add(0, OP_SUB,  8'h01, 8'hFF, 3'b110, 3'd4, 0);
        add(0, OP_LSL,  8'h00, 8'hFE, 3'b110, 3'd4, 0);
        add(0, OP_XOR,  8'hFF, 8'h01, 3'b000, 3'd4, 0);
        add(0, OP_OR,   8'h80, 8'h81, 3'b010, 3'd4, 0);
        add(0, OP_AND,  8'h0F, 8'h01, 3'b000, 3'd4, 0);
        add(0, OP_GT,   8'h80, 8'h01, 3'b001, 3'd4, 0);

        for (int i = 0; i < vq.size(); i++)
            run_vec(vq[i], i);

        // Strobe held high for 5 cycles fires once
        do_reset();
        pulses = 0;
        @(negedge clk);
        op = OP_ADD; operand = 8'h01; op_strobe = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        op_strobe = 1'b0;
        @(negedge clk);
        if (done) pulses++;
        check("hold pulses", pulses, 1);
        check("hold acc", acc_out, 8'h01);
        check("hold hist", hist_count, 1);

        // Reset asserted while strobe high: no execution until a fresh rising edge
        pulses = 0;
        @(negedge clk);
        op_strobe = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst_hold pulses", pulses, 0);
        check("rst_hold acc", acc_out, 8'h00);
        check("rst_hold hist", hist_count, 0);
        op_strobe = 1'b0;
        @(negedge clk);
        op_strobe = 1'b1;
        @(negedge clk);
        check("rst_rise done", done, 1);
        check("rst_rise acc", acc_out, 8'h01);
        op_strobe = 1'b0;
        @(negedge clk);

        // Edge during ena=0 is lost, even if ena returns while strobe stays high
        ena = 1'b0;
        op_strobe = 1'b1;
        @(negedge clk);
        check("ena0 done", done, 0);
        check("ena0 acc", acc_out, 8'h01);
        ena = 1'b1;
        @(negedge clk);
        check("ena_back done", done, 0);
        @(negedge clk);
        check("ena_back acc", acc_out, 8'h01);
        check("ena_back hist", hist_count, 1);
        op_strobe = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
